// File: rtl/text_layer.sv
// Character-cell text overlay: host-written char buffer -> font_addr / bit index / draw_text, 2-cycle read with +2 px lookahead.
// No stalls on the read path; host writes are dropped (wr_ack=0) while a clear sweep runs, so the host polls busy.
module text_layer #(
    parameter int TEXT_X0 = 16,
    parameter int TEXT_Y0 = 16,
    parameter int COLS    = 40,
    parameter int ROWS    = 2,
    parameter int ADDR_W  = 11
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clear,
    output logic              busy,
    output logic              wr_ack,
    output logic [10:0]       font_addr,
    output logic [3:0]        text_offset,
    output logic              draw_text
);

    localparam int DEPTH = COLS * ROWS;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       mem [0:DEPTH-1];
    logic [7:0]       q;

    logic [10:0]      lx;
    logic [9:0]       ly;
    logic             in_region;
    logic [IDX_W-1:0] rd_idx;

    logic             host_ok;
    logic             we;
    logic [IDX_W-1:0] wa;
    logic [7:0]       wd;

    logic [3:0]       row_d;
    logic [2:0]       col_d;
    logic             in_region_d;

    // Only the low 7 bits of a character select a glyph.
    logic             unused_ok;
    assign unused_ok = q[7];

    always_comb begin
        lx        = {1'b0, DrawX} + 11'd2 - 11'(TEXT_X0);
        ly        = DrawY - 10'(TEXT_Y0);
        in_region = ({1'b0, DrawX} + 11'd2 >= 11'(TEXT_X0)) && (lx < 11'(COLS * 8)) &&
                    (DrawY >= 10'(TEXT_Y0)) && (ly < 10'(ROWS * 16));
        rd_idx    = IDX_W'(32'(ly >> 4) * COLS + 32'(lx >> 3));
    end

    always_comb begin
        host_ok = (state == IDLE) && wr_en && (wr_addr < ADDR_W'(DEPTH));
        we      = !Reset && ((state == CLEAR) || host_ok);
        wa      = (state == CLEAR) ? ptr : wr_addr[IDX_W-1:0];
        wd      = (state == CLEAR) ? 8'h20 : wr_data;
    end

    // Read-before-write: a same-edge read of the written cell returns old data.
    always_ff @(posedge Clk) begin
        if (we)
            mem[wa] <= wd;
        q <= mem[rd_idx];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy   <= 1'b1;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= host_ok;
            if (clear) begin
                state <= CLEAR;
                ptr   <= '0;
                busy  <= 1'b1;
            end else if (state == CLEAR) begin
                if (ptr == IDX_W'(DEPTH - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            row_d       <= '0;
            col_d       <= '0;
            in_region_d <= 1'b0;
            font_addr   <= '0;
            text_offset <= '0;
            draw_text   <= 1'b0;
        end else begin
            row_d       <= ly[3:0];
            col_d       <= lx[2:0];
            in_region_d <= in_region;
            font_addr   <= {q[6:0], row_d};
            text_offset <= {1'b0, 3'd7 - col_d};
            draw_text   <= in_region_d;
        end
    end

endmodule

// File: doc/text_layer.md
# text_layer

Character-cell text overlay generator that sits directly upstream of `color_mapper`. It holds a host-writable character buffer and converts each scan position into the font-ROM address, glyph bit index and text-enable flag that `color_mapper` consumes. The read path is a 2-stage pipeline with built-in 2-pixel lookahead, so outputs line up with the `DrawX`/`DrawY` that `color_mapper` sees in the same cycle. Reset and a host clear command sweep the buffer to spaces.

## Interface
Parameters:
- `TEXT_X0`, default 16: left pixel of the text region.
- `TEXT_Y0`, default 16: top pixel of the text region.
- `COLS`, default 40: character columns. Each cell is 8 px wide.
- `ROWS`, default 2: character rows. Each cell is 16 px tall.
- `ADDR_W`, default 11: width of the buffer address. Must satisfy 2^ADDR_W ≥ COLS*ROWS.

Ports:
- `Clk`  in  1: pixel clock, shared with the VGA controller. Single clock domain.
- `Reset`  in  1: synchronous, active-high.
- `DrawX`  in  10: current scan x, from the VGA controller.
- `DrawY`  in  10: current scan y, from the VGA controller.
- `wr_en`  in  1: host character write strobe.
- `wr_addr`  in  ADDR_W: cell index, computed as row*COLS + col.
- `wr_data`  in  8: character code. Only bits [6:0] select a glyph.
- `clear`  in  1: single-cycle pulse that starts a buffer clear.
- `busy`  out  1: a clear sweep is in progress.
- `wr_ack`  out  1: the host write was accepted in this cycle.
- `font_addr`  out  11: {char[6:0], glyph_row[3:0]}, sent to `color_mapper`.
- `text_offset`  out  4: font_data bit index, equal to 7 − glyph_col. Bit 3 is always 0.
- `draw_text`  out  1: the pixel lies inside the text region.

## Operation
- Buffer: COLS*ROWS × 8-bit synchronous RAM. There is one write port and one read port. Buffer contents are not reset directly; they are reset by the clear sweep.
- Lookahead coordinate: lx = DrawX + 2 − TEXT_X0, computed 11 bits wide. ly = DrawY − TEXT_Y0.
- in_region is true when DrawX + 2 ≥ TEXT_X0, lx < COLS*8, DrawY ≥ TEXT_Y0 and ly < ROWS*16.
- Read address = (ly>>4)*COLS + (lx>>3). When in_region is 0, the address is a don't-care.
- Stage 1: the RAM read is issued. ly[3:0], lx[2:0] and in_region are registered alongside it.
- Stage 2 produces the outputs:
  - font_addr = {q[6:0], row}
  - text_offset = {1'b0, 3'd7 − col}
  - draw_text = in_region_d
- Out-of-region pixels force draw_text = 0. font_addr and text_offset are still driven but have no meaning.
- Integration constraint: TEXT_X0 + COLS*8 ≤ 638, so the lookahead never crosses a line end.
- FSM states are IDLE and CLEAR:
  - In IDLE, host writes are accepted: wr_ack = wr_en and (wr_addr < COLS*ROWS). Writes to out-of-range addresses are dropped and wr_ack stays 0.
  - A `clear` pulse in IDLE moves to CLEAR with ptr = 0.
  - In CLEAR, the block writes 0x20 to buffer[ptr] and increments ptr each cycle. After ptr = COLS*ROWS − 1 is written, it returns to IDLE.
  - busy = 1 throughout CLEAR.
  - Host writes during CLEAR are dropped with wr_ack = 0. The host must poll `busy`.
  - A `clear` pulse during CLEAR restarts the sweep at ptr = 0.
- Reset behaviour:
  - Reset enters CLEAR with ptr = 0, so busy = 1 from the first edge after Reset deasserts.
  - The sweep lasts COLS*ROWS cycles.
  - Reset asserted mid-sweep restarts it.
  - Reset clears the pipeline registers, so font_addr = 0, text_offset = 0, draw_text = 0 and wr_ack = 0.
- The read path keeps running during CLEAR. The display may show a partially cleared buffer.

## Timing
- Read latency is 2 Clk edges from a DrawX/DrawY sample to the outputs.
- The +2 lookahead means outputs correspond to the DrawX currently on the bus, given DrawX increments by 1 per Clk.
- A write at edge k is visible to a read issued at edge k+1. A read and write to the same address on the same edge returns the old data.
- wr_ack is registered and asserts the cycle after the accepted wr_en.
- A clear takes exactly COLS*ROWS cycles. busy falls on the edge after the last write.

## Test plan
- Reset with default params: busy high for exactly 80 cycles, then 0. Afterwards, scanning DrawY=16 with DrawX in the cell-0 window gives font_addr=0x200 and draw_text=1.
- After the clear, write 0x41 to address 0 (wr_ack=1 the next cycle). Sweep DrawX 14..23 at DrawY=18. In the cycle DrawX=16, expect font_addr=0x412, text_offset=7 and draw_text=1. At DrawX=23, expect text_offset=0.
- Write 0x42 to address 40. At DrawY=32, DrawX=16, expect font_addr=0x420. At DrawY=48 (ly=32), expect draw_text=0.
- Region edges: DrawX=15 or DrawX=336 gives draw_text=0. DrawX=335 gives draw_text=1 with text_offset=0.
- wr_en with wr_addr=80 gives wr_ack=0 and the buffer is unchanged. A write during busy gives wr_ack=0 and the cell still reads 0x20 after the sweep.
- `clear` pulsed at sweep cycle 50 restarts the sweep: busy stays high for 80 further cycles. Asserting Reset mid-sweep gives the same restart.
